// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the MIPS fetch/decode front end
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int WB_W          = 2;
    localparam int M_W           = 2;
    localparam int EX_W          = 4;
    localparam int M_MEMREAD_BIT = 1;

    // What the PC and IF/ID register do at the next clock edge
    typedef enum logic [1:0] {
        ACT_NORMAL = 2'd0,
        ACT_FLUSH  = 2'd1,
        ACT_STALL  = 2'd2
    } fetch_act_e;

    function automatic logic [4:0] instr_rs(input logic [31:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [4:0] instr_rt(input logic [31:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detection
module hazard_detect (
    input  logic       idex_memread_i,
    input  logic [4:0] idex_rtaddr_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    output logic       hazard_o
);

    // A load writing $0 never creates a dependency, so rt=0 is excluded;
    // this also keeps a NOP in IF/ID from ever stalling.
    always_comb begin
        hazard_o = idex_memread_i
                && (idex_rtaddr_i != 5'd0)
                && ((idex_rtaddr_i == rs_i) || (idex_rtaddr_i == rt_i));
    end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - PC, IF/ID register, load-use stall and branch flush control
module if_id_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [31:0]      instr_addr_o,
    input  logic [31:0]      instr_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rtaddr_i,
    output logic [31:0]      pc_plus4_o,
    output logic [31:0]      instr_o,
    output logic             bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic        hazard;
    fetch_act_e  act;

    hazard_detect u_hazard_detect (
        .idex_memread_i (idex_memread_i),
        .idex_rtaddr_i  (idex_rtaddr_i),
        .rs_i           (instr_rs(instr_o)),
        .rt_i           (instr_rt(instr_o)),
        .hazard_o       (hazard)
    );

    assign instr_addr_o = pc;
    assign bubble_o     = hazard;
    assign pc_next_seq  = pc + 32'd4;

    // Stall beats flush: a branch resolved against stale operands is ignored
    // and re-evaluated once the load result is available.
    always_comb begin
        act = ACT_NORMAL;
        if (hazard) begin
            act = ACT_STALL;
        end else if (branch_taken_i) begin
            act = ACT_FLUSH;
        end
    end

    // PC and IF/ID register update
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc         <= RESET_PC;
            pc_plus4_o <= 32'd0;
            instr_o    <= NOP_INSTR;
        end else begin
            case (act)
                ACT_STALL: begin
                    pc         <= pc;
                    pc_plus4_o <= pc_plus4_o;
                    instr_o    <= instr_o;
                end
                ACT_FLUSH: begin
                    pc         <= branch_target_i;
                    pc_plus4_o <= 32'd0;
                    instr_o    <= NOP_INSTR;
                end
                default: begin
                    pc         <= pc_next_seq;
                    pc_plus4_o <= pc_next_seq;
                    instr_o    <= instr_i;
                end
            endcase
        end
    end

    // Saturating stall/flush performance counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (act == ACT_STALL && stall_cnt_o != '1) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (act == ACT_FLUSH && flush_cnt_o != '1) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end

endmodule
